// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = (a - b - bin) mod 2^WIDTH, LSB first.
// One full-subtractor cell plus a borrow flop processes one bit per clock.
//
// Handshake: start is sampled only in IDLE. The operation is accepted on that
// edge. busy is high in RUN and DONE. done pulses for one cycle. diff and bout
// are valid from the done cycle and hold until the next completion or reset.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] res_next;

    // Full-subtractor cell on the current LSBs and the running borrow
    always_comb begin
        d        = sa[0] ^ sb[0] ^ br;
        br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        res_next = {d, res[WIDTH-1:1]};
    end

    // Control FSM, operand shifters, result assembly and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa  <= {1'b0, sa[WIDTH-1:1]};
                    sb  <= {1'b0, sb[WIDTH-1:1]};
                    br  <= br_next;
                    res <= res_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        // Only the completed word ever reaches diff
                        diff  <= res_next;
                        bout  <= br_next;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // A start seen here is dropped, not queued
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic
    function automatic logic [W:0] ref_sub(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                           input logic ibin);
        longint full;
        logic [W-1:0] rd;
        logic rb;
        full = longint'(ia) - longint'(ib) - longint'(ibin);
        rd   = full[W-1:0];
        rb   = (longint'(ia) < (longint'(ib) + longint'(ibin)));
        return {rb, rd};
    endfunction

    // Issue one operation; report observed result and timing.
    // Index 0 is the negedge right after the accepting edge.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                         output logic [W-1:0] od, output logic ob,
                         output int lat, output int busy_n, output int done_n);
        @(negedge clk);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        lat = -1; busy_n = 0; done_n = 0; od = '0; ob = 1'b0;
        for (int i = 0; i < W + 6; i++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat < 0) begin
                    lat = i; od = diff; ob = bout;
                end
            end
            if (i != W + 5) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff got=%h exp=00", diff); end
        checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout got=%b exp=0", bout); end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_no_start got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        logic [W-1:0] od; logic ob; int lat, bn, dn;
        logic [W:0] e;
        e = ref_sub(8'h35, 8'h12, 1'b0);
        do_op(8'h35, 8'h12, 1'b0, od, ob, lat, bn, dn);
        checks++; if (lat !== W) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, W); end
        checks++; if (bn !== W + 1) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", bn, W + 1); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", dn); end
        checks++; if (od !== e[W-1:0]) begin errors++; $display("FAIL basic_diff got=%h exp=%h", od, e[W-1:0]); end
        checks++; if (ob !== e[W]) begin errors++; $display("FAIL basic_bout got=%b exp=%b", ob, e[W]); end
        repeat (3) @(negedge clk);
        checks++; if (diff !== e[W-1:0] || bout !== e[W])
            begin errors++; $display("FAIL basic_hold got=%h/%b exp=%h/%b", diff, bout, e[W-1:0], e[W]); end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4] = '{8'h00, 8'hFF, 8'h80, 8'h10};
        logic [W-1:0] vb [4] = '{8'h01, 8'hFF, 8'h7F, 8'h00};
        logic         vc [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [W-1:0] od; logic ob; int lat, bn, dn;
        logic [W:0] e;
        for (int k = 0; k < 4; k++) begin
            e = ref_sub(va[k], vb[k], vc[k]);
            do_op(va[k], vb[k], vc[k], od, ob, lat, bn, dn);
            checks++; if (lat !== W) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", k, lat, W); end
            checks++; if (od !== e[W-1:0] || ob !== e[W])
                begin errors++; $display("FAIL dir%0d_result got=%h/%b exp=%h/%b", k, od, ob, e[W-1:0], e[W]); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, od; logic rc, ob; int lat, bn, dn;
        logic [W:0] e;
        for (int k = 0; k < 25; k++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom_range(0, 1));
            e = ref_sub(ra, rb, rc);
            do_op(ra, rb, rc, od, ob, lat, bn, dn);
            checks++; if (lat !== W || dn !== 1 || od !== e[W-1:0] || ob !== e[W])
                begin errors++; $display("FAIL rand%0d a=%h b=%h bin=%b got=%h/%b lat=%0d exp=%h/%b lat=%0d",
                                         k, ra, rb, rc, od, ob, lat, e[W-1:0], e[W], W); end
        end
    endtask

    task automatic test_start_ignored();
        int idx, lat1, lat2;
        logic [W-1:0] d1, d2; logic b1, b2;
        logic [W:0] e1, e2;
        e1 = ref_sub(8'h35, 8'h12, 1'b0);
        e2 = ref_sub(8'h01, 8'h02, 1'b0);
        @(negedge clk);
        a = 8'h35; b = 8'h12; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'h01; b = 8'h02; bin = 1'b0;   // start stays high through RUN and DONE
        lat1 = -1; d1 = '0; b1 = 1'b0;
        for (idx = 0; idx < W + 4 && lat1 < 0; idx++) begin
            if (done) begin lat1 = idx; d1 = diff; b1 = bout; end
            else @(negedge clk);
        end
        checks++; if (lat1 !== W) begin errors++; $display("FAIL ign_latency got=%0d exp=%0d", lat1, W); end
        checks++; if (d1 !== e1[W-1:0] || b1 !== e1[W])
            begin errors++; $display("FAIL ign_first got=%h/%b exp=%h/%b", d1, b1, e1[W-1:0], e1[W]); end
        @(negedge clk);   // IDLE, start still high: accepted on the next edge
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle_gap got=%b exp=0", busy); end
        @(negedge clk);
        start = 1'b0;
        lat2 = -1; d2 = '0; b2 = 1'b0;
        for (int i = 0; i < W + 4 && lat2 < 0; i++) begin
            if (done) begin lat2 = i; d2 = diff; b2 = bout; end
            else @(negedge clk);
        end
        checks++; if (lat2 !== W) begin errors++; $display("FAIL ign_second_latency got=%0d exp=%0d", lat2, W); end
        checks++; if (d2 !== e2[W-1:0] || b2 !== e2[W])
            begin errors++; $display("FAIL ign_second got=%h/%b exp=%h/%b", d2, b2, e2[W-1:0], e2[W]); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int dn;
        logic [W-1:0] od; logic ob; int lat, bn, dn2;
        logic [W:0] e;
        @(negedge clk);
        a = 8'hAA; b = 8'h55; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);   // four RUN edges done
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (diff !== 8'h00 || bout !== 1'b0)
            begin errors++; $display("FAIL midrst_result got=%h/%b exp=00/0", diff, bout); end
        dn = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (done || busy) dn++;
            @(negedge clk);
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", dn); end
        e = ref_sub(8'hAA, 8'h55, 1'b0);
        do_op(8'hAA, 8'h55, 1'b0, od, ob, lat, bn, dn2);
        checks++; if (lat !== W || od !== e[W-1:0] || ob !== e[W])
            begin errors++; $display("FAIL midrst_fresh got=%h/%b lat=%0d exp=%h/%b lat=%0d",
                                     od, ob, lat, e[W-1:0], e[W], W); end
    endtask

    task automatic test_back_to_back();
        int idx, first_done, second_done;
        @(negedge clk);
        a = 8'h0F; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Next start arrives at the earliest legal point: W+2 edges after acceptance
        first_done = -1; second_done = -1;
        for (idx = 0; idx < 3 * W; idx++) begin
            if (idx == W + 1) begin a = 8'h20; b = 8'h21; bin = 1'b1; start = 1'b1; end
            if (idx == W + 2) start = 1'b0;
            if (done && first_done < 0) first_done = idx;
            else if (done && second_done < 0) second_done = idx;
            @(negedge clk);
        end
        checks++; if (second_done - first_done !== W + 2)
            begin errors++; $display("FAIL b2b_interval got=%0d exp=%0d", second_done - first_done, W + 2); end
        checks++; if (diff !== 8'hFE || bout !== 1'b1)
            begin errors++; $display("FAIL b2b_result got=%h/%b exp=fe/1", diff, bout); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_directed();
        test_random();
        test_start_ignored();
        test_reset_midrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial unsigned subtractor: the inverse-operation counterpart to the team's ripple full-adder blocks. It computes diff = a - b - bin over WIDTH clock cycles, LSB first, using one full-subtractor cell and a borrow flip-flop. It serves area-constrained datapaths that trade latency for a single-bit arithmetic slice. A start/busy/done handshake makes it the sequential building block for multi-cycle ALU sequencers.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request to begin a subtraction; sampled only in IDLE
a  input  WIDTH  minuend; captured on the accepted start edge
b  input  WIDTH  subtrahend; captured on the accepted start edge
bin  input  1  borrow-in; captured on the accepted start edge
busy  output  1  high while in RUN or DONE
done  output  1  one-cycle pulse; diff/bout valid from this cycle onward
diff  output  WIDTH  result (a - b - bin) mod 2^WIDTH
bout  output  1  final borrow; 1 iff a < b + bin (unsigned)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst high at an edge): state=IDLE; busy=0, done=0, diff=0, bout=0; internal shift registers, borrow flop and bit counter cleared. Reset overrides every other input, including start in the same cycle, and aborts an in-progress operation mid-run with no partial result retained.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1 at an edge, capture a into shift reg A, b into shift reg B, bin into borrow flop br; counter=0; go to RUN. Otherwise stay. diff/bout hold their last values.
- RUN: each edge processes one bit:
  - d = A[0] ^ B[0] ^ br
  - br_next = (~A[0] & B[0]) | (~(A[0] ^ B[0]) & br)
  - A and B shift right by 1; d shifts into the result register from the MSB side; counter increments.
  - After the edge where counter reaches WIDTH-1, i.e. the WIDTH-th bit is processed: go to DONE, load diff from the completed result register, and load bout from br_next.
- DONE: done=1 for exactly one cycle; unconditionally return to IDLE at the next edge.
- start handling outside IDLE: start in RUN or DONE is ignored, not queued. a/b/bin changes after capture have no effect.
- Latency: start accepted at edge E0; done high in the cycle after edge E0+WIDTH. For WIDTH=8, done rises 8 cycles after busy rises. Minimum issue interval is WIDTH+2 cycles (start can next be accepted at edge E0+WIDTH+2).
- diff/bout update only on entry to DONE. They hold through IDLE until the next completed operation or reset. The result register's intermediate content is not visible on diff.
- busy: rises the cycle after the accepted start edge; falls the cycle after DONE.
- Wrap-around: results are modulo 2^WIDTH. Underflow is indicated only by bout=1; no saturation.

Test Plan:
- Reset: hold rst 2 cycles with start=1, a=0xFF -> busy=0, done=0, diff=0x00, bout=0; no operation starts.
- Basic (WIDTH=8): a=0x35, b=0x12, bin=0, start 1 cycle -> busy for 9 cycles; done pulses 8 cycles after busy rises; diff=0x23, bout=0; values hold afterward in IDLE.
- Underflow: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
- Borrow-in ripple: a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0. Also a=0x10, b=0x00, bin=1 -> diff=0x0F, bout=0.
- Start ignored: during RUN, re-assert start with a=0x01, b=0x02 and hold it high through the DONE cycle -> first result (a=0x35, b=0x12) completes unchanged as 0x23; start still high in the following IDLE cycle launches the new operation -> diff=0xFF, bout=1.
- Reset mid-run: start a=0xAA, b=0x55; assert rst after 4 RUN cycles -> next cycle busy=0, diff=0x00, bout=0, no done pulse. A fresh start with a=0xAA, b=0x55, bin=0 -> diff=0x55, bout=0.
